// File: rtl/mux_out_sink.sv
// mux_out_sink: collects bytes from the selected lane of a 4-channel mux,
// packs them per channel into 32-bit little-endian words, and queues the
// completed words with their channel tag in a first-word-fall-through FIFO.
module mux_out_sink #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DROP_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 chan,
   input  logic [7:0]                 out_data0,
   input  logic [7:0]                 out_data1,
   input  logic [7:0]                 out_data2,
   input  logic [7:0]                 out_data3,
   input  logic                       valid,
   input  logic                       flush,
   output logic                       word_valid,
   output logic [31:0]                word_data,
   output logic [1:0]                 word_chan,
   input  logic                       word_ready,
   output logic                       overflow,
   output logic [DROP_W-1:0]          drop_cnt,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [1:0]    idx  [4];
   logic [23:0]   part [4];
   logic [33:0]   mem  [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   logic [7:0] byte_in;
   logic       accept;
   logic       push_req;
   logic       push_ok;
   logic       pop;
   logic       full;

   // Select the byte on the lane the mux is currently driving.
   always_comb begin
      byte_in = out_data0;
      case (chan)
         2'd0: byte_in = out_data0;
         2'd1: byte_in = out_data1;
         2'd2: byte_in = out_data2;
         2'd3: byte_in = out_data3;
         default: byte_in = out_data0;
      endcase
   end

   assign accept     = valid & ~flush;
   assign push_req   = accept & (idx[chan] == 2'd3);
   assign full       = (level == LW'(DEPTH));
   assign word_valid = (level != '0);
   assign pop        = word_valid & word_ready;
   // A full FIFO still takes a word when the head leaves on the same edge;
   // the write slot then coincides with the slot being popped.
   assign push_ok    = push_req & (~full | pop);

   assign {word_chan, word_data} = mem[rd_ptr];

   // Per-channel byte index and partial-word assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 4; i++) begin
            idx[i]  <= '0;
            part[i] <= '0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < 4; i++) begin
            idx[i] <= '0;
         end
      end else if (valid) begin
         if (idx[chan] != 2'd3) begin
            part[chan][{idx[chan], 3'b000} +: 8] <= byte_in;
            idx[chan] <= idx[chan] + 2'd1;
         end else begin
            idx[chan] <= '0;
         end
      end
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {chan, byte_in, part[chan]};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Sticky overflow flag and saturating count of dropped words.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (push_req && !push_ok) begin
         overflow <= 1'b1;
         if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux_out_sink.sv
// tb_mux_out_sink: directed self-checking bench for mux_out_sink.
module tb_mux_out_sink;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned DROP_W = 8;
   localparam int unsigned LW     = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst;
   logic [1:0]        chan;
   logic [7:0]        out_data0;
   logic [7:0]        out_data1;
   logic [7:0]        out_data2;
   logic [7:0]        out_data3;
   logic              valid;
   logic              flush;
   logic              word_valid;
   logic [31:0]       word_data;
   logic [1:0]        word_chan;
   logic              word_ready;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;
   logic [LW-1:0]     level;

   int checks = 0;
   int errors = 0;

   mux_out_sink #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .chan       (chan),
      .out_data0  (out_data0),
      .out_data1  (out_data1),
      .out_data2  (out_data2),
      .out_data3  (out_data3),
      .valid      (valid),
      .flush      (flush),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_chan  (word_chan),
      .word_ready (word_ready),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are observed 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one byte on lane ch for one edge; idle lanes carry 0xFF.
   task automatic send_byte(input logic [1:0] ch, input logic [7:0] b);
      chan      = ch;
      out_data0 = 8'hFF;
      out_data1 = 8'hFF;
      out_data2 = 8'hFF;
      out_data3 = 8'hFF;
      case (ch)
         2'd0: out_data0 = b;
         2'd1: out_data1 = b;
         2'd2: out_data2 = b;
         default: out_data3 = b;
      endcase
      valid = 1'b1;
      step();
      valid = 1'b0;
   endtask

   task automatic send_word(input logic [1:0] ch, input logic [31:0] w);
      send_byte(ch, w[7:0]);
      send_byte(ch, w[15:8]);
      send_byte(ch, w[23:16]);
      send_byte(ch, w[31:24]);
   endtask

   task automatic pop_one();
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
   endtask

   function automatic logic [31:0] pat_word(input int k);
      logic [7:0] b0;
      b0 = 8'(4 * k);
      return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %0b expected 0", word_valid); end
      checks++; if (word_data !== 32'h0) begin errors++; $display("FAIL reset_word_data: got %h expected 00000000", word_data); end
      checks++; if (word_chan !== 2'd0) begin errors++; $display("FAIL reset_word_chan: got %0d expected 0", word_chan); end
      checks++; if (level !== LW'(0)) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
      checks++; if (drop_cnt !== DROP_W'(0)) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
   endtask

   task automatic test_single();
      // Idle cycles with junk on the lanes must not be sampled.
      chan = 2'd2; out_data2 = 8'h99; valid = 1'b0;
      step();
      step();
      word_ready = 1'b1;
      send_byte(2'd2, 8'h11);
      send_byte(2'd2, 8'h22);
      send_byte(2'd2, 8'h33);
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", word_valid); end
      send_byte(2'd2, 8'h44);
      checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", word_valid); end
      checks++; if (word_data !== 32'h44332211) begin errors++; $display("FAIL single_data: got %h expected 44332211", word_data); end
      checks++; if (word_chan !== 2'd2) begin errors++; $display("FAIL single_chan: got %0d expected 2", word_chan); end
      step();
      word_ready = 1'b0;
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %0b expected 0", word_valid); end
      checks++; if (level !== LW'(0)) begin errors++; $display("FAIL single_level: got %0d expected 0", level); end
   endtask

   task automatic test_interleave();
      word_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_byte(2'd0, 8'hA0 + 8'(i));
         send_byte(2'd1, 8'hB0 + 8'(i));
      end
      checks++; if (level !== LW'(2)) begin errors++; $display("FAIL interleave_level: got %0d expected 2", level); end
      checks++; if (word_data !== 32'hA3A2A1A0) begin errors++; $display("FAIL interleave_data0: got %h expected a3a2a1a0", word_data); end
      checks++; if (word_chan !== 2'd0) begin errors++; $display("FAIL interleave_chan0: got %0d expected 0", word_chan); end
      pop_one();
      checks++; if (word_data !== 32'hB3B2B1B0) begin errors++; $display("FAIL interleave_data1: got %h expected b3b2b1b0", word_data); end
      checks++; if (word_chan !== 2'd1) begin errors++; $display("FAIL interleave_chan1: got %0d expected 1", word_chan); end
      pop_one();
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL interleave_empty: got %0b expected 0", word_valid); end
   endtask

   task automatic test_overflow_and_full_pop();
      word_ready = 1'b0;
      for (int k = 0; k < int'(DEPTH) + 2; k++) begin
         send_word(2'd1, pat_word(k));
      end
      checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level: got %0d expected %0d", level, DEPTH); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
      checks++; if (drop_cnt !== DROP_W'(2)) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
      // Complete a word on ch3 on the same edge the head is popped.
      send_byte(2'd3, 8'hC0);
      send_byte(2'd3, 8'hC1);
      send_byte(2'd3, 8'hC2);
      word_ready = 1'b1;
      send_byte(2'd3, 8'hC3);
      word_ready = 1'b0;
      checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL fullpop_level: got %0d expected %0d", level, DEPTH); end
      checks++; if (drop_cnt !== DROP_W'(2)) begin errors++; $display("FAIL fullpop_drop_cnt: got %0d expected 2", drop_cnt); end
      for (int k = 1; k < int'(DEPTH); k++) begin
         checks++; if (word_valid !== 1'b1 || word_data !== pat_word(k) || word_chan !== 2'd1) begin
            errors++; $display("FAIL drain_word%0d: got v=%0b %h ch%0d expected v=1 %h ch1", k, word_valid, word_data, word_chan, pat_word(k));
         end
         pop_one();
      end
      checks++; if (word_data !== 32'hC3C2C1C0 || word_chan !== 2'd3) begin
         errors++; $display("FAIL drain_last: got %h ch%0d expected c3c2c1c0 ch3", word_data, word_chan);
      end
      pop_one();
      checks++; if (level !== LW'(0)) begin errors++; $display("FAIL drain_level: got %0d expected 0", level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain_overflow_sticky: got %0b expected 1", overflow); end
   endtask

   task automatic test_flush();
      send_byte(2'd3, 8'hAA);
      send_byte(2'd3, 8'hBB);
      flush = 1'b1;
      send_byte(2'd3, 8'h55);
      flush = 1'b0;
      send_word(2'd3, 32'h04030201);
      checks++; if (level !== LW'(1)) begin errors++; $display("FAIL flush_level: got %0d expected 1", level); end
      checks++; if (word_data !== 32'h04030201) begin errors++; $display("FAIL flush_data: got %h expected 04030201", word_data); end
      checks++; if (word_chan !== 2'd3) begin errors++; $display("FAIL flush_chan: got %0d expected 3", word_chan); end
      checks++; if (drop_cnt !== DROP_W'(2) || overflow !== 1'b1) begin
         errors++; $display("FAIL flush_keeps_drop: got cnt=%0d ovf=%0b expected cnt=2 ovf=1", drop_cnt, overflow);
      end
      pop_one();
   endtask

   task automatic test_saturate();
      word_ready = 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) send_word(2'd0, pat_word(k));
      // 2 drops already counted; 253 more reach all-ones exactly.
      for (int k = 0; k < 253; k++) send_word(2'd0, pat_word(k));
      checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_reach: got %0d expected 255", drop_cnt); end
      for (int k = 0; k < 3; k++) send_word(2'd0, pat_word(k));
      checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %0d expected 255", drop_cnt); end
      checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL sat_level: got %0d expected %0d", level, DEPTH); end
   endtask

   task automatic test_reset_mid();
      word_ready = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      for (int k = 0; k < 3; k++) send_word(2'd0, pat_word(k));
      send_byte(2'd1, 8'hEE);
      send_byte(2'd1, 8'hEF);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (word_valid !== 1'b0 || level !== LW'(0)) begin
         errors++; $display("FAIL rstmid_fifo: got v=%0b lvl=%0d expected v=0 lvl=0", word_valid, level);
      end
      checks++; if (word_data !== 32'h0 || word_chan !== 2'd0) begin
         errors++; $display("FAIL rstmid_head: got %h ch%0d expected 00000000 ch0", word_data, word_chan);
      end
      checks++; if (overflow !== 1'b0 || drop_cnt !== DROP_W'(0)) begin
         errors++; $display("FAIL rstmid_drop: got ovf=%0b cnt=%0d expected 0 0", overflow, drop_cnt);
      end
      send_word(2'd1, 32'h9A785634);
      checks++; if (level !== LW'(1)) begin errors++; $display("FAIL rstmid_one_word: got %0d expected 1", level); end
      checks++; if (word_data !== 32'h9A785634 || word_chan !== 2'd1) begin
         errors++; $display("FAIL rstmid_data: got %h ch%0d expected 9a785634 ch1", word_data, word_chan);
      end
      pop_one();
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty: got %0b expected 0", word_valid); end
   endtask

   initial begin
      rst        = 1'b1;
      chan       = 2'd0;
      out_data0  = 8'h00;
      out_data1  = 8'h00;
      out_data2  = 8'h00;
      out_data3  = 8'h00;
      valid      = 1'b0;
      flush      = 1'b0;
      word_ready = 1'b0;
      test_reset();
      test_single();
      test_interleave();
      test_overflow_and_full_pop();
      test_flush();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
